// File: rtl/multi_alarm_clock_core.sv
// HH:MM:SS timekeeping core with NUM_ALARMS alarm channels, each with its own
// ring/snooze state machine, and a registered BCD display with 12/24-hour formatting.
module multi_alarm_clock_core #(
  parameter int NUM_ALARMS     = 4,
  parameter int SNOOZE_MINUTES = 9,
  parameter int RING_SECONDS   = 60,
  parameter int START_HOURS    = 0,
  parameter int START_MINUTES  = 0,
  localparam int AW            = $clog2(NUM_ALARMS)
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Sec_Pulse,
  input  logic                  i_Mode_24H,
  input  logic                  i_Edit_Time,
  input  logic                  i_Edit_Alarm,
  input  logic [AW-1:0]         i_Alarm_Sel,
  input  logic                  i_Minutes_Inc,
  input  logic                  i_Hours_Inc,
  input  logic [NUM_ALARMS-1:0] i_Alarm_Enable,
  input  logic                  i_Snooze,
  input  logic                  i_Dismiss,
  output logic [23:0]           o_Display,
  output logic                  o_PM,
  output logic [NUM_ALARMS-1:0] o_Ringing,
  output logic                  o_Alarm_Any,
  output logic                  o_Alarm_Enabled
);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} chan_state_t;

  localparam logic [4:0]  H_START   = 5'(START_HOURS);
  localparam logic [5:0]  M_START   = 6'(START_MINUTES);
  localparam logic [7:0]  RING_LOAD = 8'(RING_SECONDS);
  localparam logic [11:0] SNZ_LOAD  = 12'(SNOOZE_MINUTES * 60);

  logic [4:0] hours, hours_nxt;
  logic [5:0] mins, mins_nxt;
  logic [5:0] secs, secs_nxt;

  logic [4:0] alarm_h     [NUM_ALARMS];
  logic [5:0] alarm_m     [NUM_ALARMS];
  logic [4:0] alarm_h_nxt [NUM_ALARMS];
  logic [5:0] alarm_m_nxt [NUM_ALARMS];

  chan_state_t state     [NUM_ALARMS];
  chan_state_t state_nxt [NUM_ALARMS];
  logic [7:0]  ring_cnt  [NUM_ALARMS];
  logic [7:0]  ring_nxt  [NUM_ALARMS];
  logic [11:0] snz_cnt   [NUM_ALARMS];
  logic [11:0] snz_nxt   [NUM_ALARMS];

  logic [NUM_ALARMS-1:0] hit;
  logic [NUM_ALARMS-1:0] ringing_nxt;
  logic                  match_tick;
  logic                  alarm_edit;
  logic                  sel_valid;
  logic [4:0]            sel_h;
  logic [5:0]            sel_m;
  logic [4:0]            src_h, disp_h;
  logic [5:0]            src_m, src_s;
  logic                  pm_nxt;
  logic [23:0]           display_nxt;

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  assign alarm_edit = i_Edit_Alarm && !i_Edit_Time;

  always_comb begin
    hours_nxt = hours;
    mins_nxt  = mins;
    secs_nxt  = secs;
    if (i_Edit_Time) begin
      secs_nxt = '0;
      if (i_Minutes_Inc) mins_nxt  = (mins == 6'd59) ? '0 : mins + 6'd1;
      if (i_Hours_Inc)   hours_nxt = (hours == 5'd23) ? '0 : hours + 5'd1;
    end else if (i_Sec_Pulse) begin
      if (secs == 6'd59) begin
        secs_nxt = '0;
        if (mins == 6'd59) begin
          mins_nxt  = '0;
          hours_nxt = (hours == 5'd23) ? '0 : hours + 5'd1;
        end else begin
          mins_nxt = mins + 6'd1;
        end
      end else begin
        secs_nxt = secs + 6'd1;
      end
    end
  end

  // A match is judged against the time this pulse produces, so it fires on the HH:MM:00 edge.
  assign match_tick = i_Sec_Pulse && !i_Edit_Time && (secs_nxt == 6'd0);

  always_comb begin
    sel_valid = 1'b0;
    sel_h     = '0;
    sel_m     = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      alarm_h_nxt[i] = alarm_h[i];
      alarm_m_nxt[i] = alarm_m[i];
      if (i_Alarm_Sel == AW'(i)) begin
        sel_valid = 1'b1;
        sel_h     = alarm_h[i];
        sel_m     = alarm_m[i];
        if (alarm_edit) begin
          if (i_Minutes_Inc) alarm_m_nxt[i] = (alarm_m[i] == 6'd59) ? '0 : alarm_m[i] + 6'd1;
          if (i_Hours_Inc)   alarm_h_nxt[i] = (alarm_h[i] == 5'd23) ? '0 : alarm_h[i] + 5'd1;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      hit[i] = match_tick && i_Alarm_Enable[i] &&
               (hours_nxt == alarm_h[i]) && (mins_nxt == alarm_m[i]);
    end
  end

  // Branch order encodes per-channel priority: disable, dismiss, snooze, match, expiry.
  always_comb begin
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      state_nxt[i] = state[i];
      ring_nxt[i]  = ring_cnt[i];
      snz_nxt[i]   = snz_cnt[i];
      if (!i_Alarm_Enable[i] || i_Dismiss) begin
        state_nxt[i] = IDLE;
        ring_nxt[i]  = '0;
        snz_nxt[i]   = '0;
      end else if (i_Snooze && state[i] == RINGING) begin
        state_nxt[i] = SNOOZED;
        ring_nxt[i]  = '0;
        snz_nxt[i]   = SNZ_LOAD;
      end else if (hit[i] && state[i] != RINGING) begin
        state_nxt[i] = RINGING;
        ring_nxt[i]  = RING_LOAD;
        snz_nxt[i]   = '0;
      end else if (i_Sec_Pulse) begin
        case (state[i])
          RINGING: begin
            if (ring_cnt[i] == 8'd1) begin
              state_nxt[i] = IDLE;
              ring_nxt[i]  = '0;
            end else begin
              ring_nxt[i] = ring_cnt[i] - 8'd1;
            end
          end
          SNOOZED: begin
            if (snz_cnt[i] == 12'd1) begin
              state_nxt[i] = RINGING;
              ring_nxt[i]  = RING_LOAD;
              snz_nxt[i]   = '0;
            end else begin
              snz_nxt[i] = snz_cnt[i] - 12'd1;
            end
          end
          default: ;
        endcase
      end
      ringing_nxt[i] = (state_nxt[i] == RINGING);
    end
  end

  always_comb begin
    if (alarm_edit && sel_valid) begin
      src_h = sel_h;
      src_m = sel_m;
      src_s = '0;
    end else begin
      src_h = hours;
      src_m = mins;
      src_s = secs;
    end
    disp_h = src_h;
    pm_nxt = 1'b0;
    if (!i_Mode_24H) begin
      if (src_h == 5'd0) begin
        disp_h = 5'd12;
      end else if (src_h >= 5'd12) begin
        pm_nxt = 1'b1;
        if (src_h != 5'd12) disp_h = src_h - 5'd12;
      end
    end
    display_nxt = {to_bcd({1'b0, disp_h}), to_bcd(src_m), to_bcd(src_s)};
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      hours           <= H_START;
      mins            <= M_START;
      secs            <= '0;
      o_Display       <= '0;
      o_PM            <= 1'b0;
      o_Ringing       <= '0;
      o_Alarm_Any     <= 1'b0;
      o_Alarm_Enabled <= 1'b0;
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        alarm_h[i]  <= '0;
        alarm_m[i]  <= '0;
        state[i]    <= IDLE;
        ring_cnt[i] <= '0;
        snz_cnt[i]  <= '0;
      end
    end else begin
      hours           <= hours_nxt;
      mins            <= mins_nxt;
      secs            <= secs_nxt;
      o_Display       <= display_nxt;
      o_PM            <= pm_nxt;
      o_Ringing       <= ringing_nxt;
      o_Alarm_Any     <= |ringing_nxt;
      o_Alarm_Enabled <= |i_Alarm_Enable;
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        alarm_h[i]  <= alarm_h_nxt[i];
        alarm_m[i]  <= alarm_m_nxt[i];
        state[i]    <= state_nxt[i];
        ring_cnt[i] <= ring_nxt[i];
        snz_cnt[i]  <= snz_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_alarm_clock_core.sv
// Directed bench for multi_alarm_clock_core: expectations are queued as stimulus
// is applied and compared against the DUT outputs once their latency has elapsed.
module tb_multi_alarm_clock_core;

  localparam int NA = 3;  // non-power-of-two so an out-of-range select is reachable
  localparam int AWB = $clog2(NA);

  logic            clk = 1'b0;
  logic            rst, sec, mode24, edit_time, edit_alarm, min_inc, hr_inc, snooze, dismiss;
  logic [AWB-1:0]  sel;
  logic [NA-1:0]   enable;
  logic [23:0]     display;
  logic            pm, any, enabled;
  logic [NA-1:0]   ringing;

  typedef struct {
    string       tag;
    int          kind;
    logic [23:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   th, tm, ts;

  multi_alarm_clock_core #(
    .NUM_ALARMS(NA), .SNOOZE_MINUTES(1), .RING_SECONDS(3),
    .START_HOURS(7), .START_MINUTES(30)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Sec_Pulse(sec), .i_Mode_24H(mode24),
    .i_Edit_Time(edit_time), .i_Edit_Alarm(edit_alarm), .i_Alarm_Sel(sel),
    .i_Minutes_Inc(min_inc), .i_Hours_Inc(hr_inc), .i_Alarm_Enable(enable),
    .i_Snooze(snooze), .i_Dismiss(dismiss), .o_Display(display), .o_PM(pm),
    .o_Ringing(ringing), .o_Alarm_Any(any), .o_Alarm_Enabled(enabled)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input string tag, input int kind, input logic [23:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t        e;
    logic [23:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       obs = display;
        1:       obs = {23'b0, pm};
        2:       obs = {{(24-NA){1'b0}}, ringing};
        3:       obs = {23'b0, any};
        default: obs = {23'b0, enabled};
      endcase
      n_checks++;
      assert (obs === e.val)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic sec_pulses(input int n);
    for (int k = 0; k < n; k++) begin
      sec = 1'b1;
      tick(1);
      sec = 1'b0;
      ts++;
      if (ts == 60) begin
        ts = 0;
        tm++;
        if (tm == 60) begin
          tm = 0;
          th = (th + 1) % 24;
        end
      end
    end
  endtask

  task automatic set_time(input int h, input int m);
    int dh, dm;
    dh = (h - th + 24) % 24;
    dm = (m - tm + 60) % 60;
    edit_time = 1'b1;
    for (int k = 0; k < ((dh > dm) ? dh : dm) || k == 0; k++) begin
      hr_inc  = (k < dh);
      min_inc = (k < dm);
      tick(1);
    end
    hr_inc    = 1'b0;
    min_inc   = 1'b0;
    edit_time = 1'b0;
    tick(1);
    th = h;
    tm = m;
    ts = 0;
  endtask

  initial begin
    rst = 1'b1; sec = 1'b0; mode24 = 1'b1; edit_time = 1'b0; edit_alarm = 1'b0;
    min_inc = 1'b0; hr_inc = 1'b0; snooze = 1'b0; dismiss = 1'b0; sel = '0; enable = '0;

    tick(2);
    push_exp("reset_display", 0, 24'h000000);
    push_exp("reset_pm", 1, 24'h0);
    push_exp("reset_ringing", 2, 24'h0);
    push_exp("reset_any", 3, 24'h0);
    push_exp("reset_enabled", 4, 24'h0);
    check_sb();

    rst = 1'b0;
    th = 7; tm = 30; ts = 0;
    push_exp("start_display", 0, 24'h073000);
    push_exp("start_ringing", 2, 24'h0);
    tick(2);
    check_sb();

    set_time(23, 59);
    sec_pulses(59);
    push_exp("pre_midnight", 0, 24'h235959);
    tick(1);
    check_sb();
    sec_pulses(1);
    mode24 = 1'b0;
    push_exp("midnight_12h", 0, 24'h120000);
    push_exp("midnight_pm", 1, 24'h0);
    tick(1);
    check_sb();

    set_time(13, 5);
    push_exp("pm_13_05", 0, 24'h010500);
    push_exp("pm_13_05_flag", 1, 24'h1);
    tick(1);
    check_sb();
    mode24 = 1'b1;
    push_exp("h24_13_05", 0, 24'h130500);
    push_exp("h24_pm_zero", 1, 24'h0);
    tick(1);
    check_sb();
    mode24 = 1'b0;
    set_time(12, 0);
    push_exp("noon_12h", 0, 24'h120000);
    push_exp("noon_pm", 1, 24'h1);
    tick(1);
    check_sb();
    mode24 = 1'b1;

    set_time(10, 59);
    edit_time = 1'b1; edit_alarm = 1'b1; sel = 2'd2;
    min_inc = 1'b1; hr_inc = 1'b1;
    tick(1);
    min_inc = 1'b0; hr_inc = 1'b0;
    push_exp("edit_both_time", 0, 24'h110000);
    tick(1);
    check_sb();
    th = 11; tm = 0; ts = 0;
    edit_time = 1'b0;
    push_exp("edit_both_alarm_kept", 0, 24'h000000);
    tick(1);
    check_sb();

    for (int k = 0; k < 6; k++) begin
      hr_inc = 1'b1;
      tick(1);
    end
    hr_inc = 1'b0;
    push_exp("alarm2_set", 0, 24'h060000);
    tick(1);
    check_sb();
    edit_alarm = 1'b0;
    enable = 3'b100;

    set_time(5, 59);
    sec_pulses(59);
    push_exp("pre_match_ringing", 2, 24'h0);
    push_exp("enabled_or", 4, 24'h1);
    check_sb();
    sec_pulses(1);
    push_exp("match_ringing", 2, 24'h4);
    push_exp("match_any", 3, 24'h1);
    check_sb();
    sec_pulses(2);
    push_exp("ring_two_left", 2, 24'h4);
    check_sb();
    sec_pulses(1);
    push_exp("ring_timeout", 2, 24'h0);
    push_exp("ring_timeout_any", 3, 24'h0);
    check_sb();

    set_time(5, 59);
    sec_pulses(60);
    push_exp("rering", 2, 24'h4);
    check_sb();
    snooze = 1'b1;
    tick(1);
    snooze = 1'b0;
    push_exp("snoozed", 2, 24'h0);
    check_sb();
    sec_pulses(59);
    push_exp("snooze_pending", 2, 24'h0);
    check_sb();
    sec_pulses(1);
    push_exp("snooze_expired", 2, 24'h4);
    check_sb();
    snooze = 1'b1; dismiss = 1'b1;
    tick(1);
    snooze = 1'b0; dismiss = 1'b0;
    push_exp("dismiss_wins", 2, 24'h0);
    check_sb();
    sec_pulses(60);
    push_exp("dismiss_stays_idle", 2, 24'h0);
    check_sb();

    enable = 3'b101;
    set_time(23, 59);
    sec_pulses(60);
    push_exp("ch0_ringing", 2, 24'h1);
    check_sb();
    enable = 3'b100;
    push_exp("ch0_disabled", 2, 24'h0);
    push_exp("still_enabled", 4, 24'h1);
    tick(2);
    check_sb();

    edit_alarm = 1'b1; sel = 2'd3;
    min_inc = 1'b1; hr_inc = 1'b1;
    tick(3);
    min_inc = 1'b0; hr_inc = 1'b0;
    sel = 2'd0;
    push_exp("oor_alarm0", 0, 24'h000000);
    tick(2);
    check_sb();
    sel = 2'd1;
    push_exp("oor_alarm1", 0, 24'h000000);
    tick(2);
    check_sb();
    sel = 2'd2;
    push_exp("oor_alarm2", 0, 24'h060000);
    tick(2);
    check_sb();
    edit_alarm = 1'b0;

    set_time(5, 59);
    sec_pulses(60);
    push_exp("pre_reset_ringing", 2, 24'h4);
    check_sb();
    rst = 1'b1;
    tick(1);
    push_exp("midring_reset_display", 0, 24'h000000);
    push_exp("midring_reset_pm", 1, 24'h0);
    push_exp("midring_reset_ringing", 2, 24'h0);
    push_exp("midring_reset_any", 3, 24'h0);
    push_exp("midring_reset_enabled", 4, 24'h0);
    check_sb();
    rst = 1'b0;
    th = 7; tm = 30; ts = 0;
    tick(2);
    push_exp("post_reset_display", 0, 24'h073000);
    push_exp("post_reset_ringing", 2, 24'h0);
    push_exp("post_reset_enabled", 4, 24'h1);
    check_sb();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
